// File: rtl/tq_dct_ctrl.sv
// Purpose: loads four residual rows, hands the block to a 4x4 DCT datapath, unloads four coefficient rows.
// Latency: row 3 accepted in cycle T -> capture in T+1 -> coefficient row 0 valid in T+2 (row 3 out in T+5).
// Backpressure: in_ready_o only in LOAD; out_row_o/out_last_o hold while out_valid_o=1 and out_ready_i=0.
module tq_dct_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [35:0]  in_row_i,
  output logic [143:0] dct_src_o,
  input  logic [239:0] dct_coef_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [59:0]  out_row_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic [15:0]  blk_cnt_o
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CAPT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        in_acc;
  logic        out_acc;
  logic [1:0]  in_cnt;
  logic [1:0]  out_cnt;
  logic [15:0] blk_cnt;

  // Row r of each buffer is packed at the low-to-high position matching sample/coefficient index 4r+c.
  logic [3:0][35:0] src_buf;
  logic [3:0][59:0] coef_buf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; flush overrides whatever the handshakes would have done.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    in_acc      = 1'b0;
    out_acc     = 1'b0;
    case (state)
      LOAD: begin
        in_ready_o = 1'b1;
        in_acc     = in_valid_i;
        if (in_valid_i && (in_cnt == 2'd3)) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        state_nxt = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        out_last_o  = (out_cnt == 2'd3);
        out_acc     = out_ready_i;
        if (out_ready_i && (out_cnt == 2'd3)) begin
          state_nxt = LOAD;
        end
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
    if (flush_i) begin
      state_nxt = LOAD;
    end
  end

  // Row counters and completed-block counter; a flush clears the row counters but never counts a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= 2'd0;
      out_cnt <= 2'd0;
      blk_cnt <= 16'd0;
    end else if (flush_i) begin
      in_cnt  <= 2'd0;
      out_cnt <= 2'd0;
    end else begin
      if (in_acc) begin
        in_cnt <= in_cnt + 2'd1;
      end
      if (out_acc) begin
        out_cnt <= out_cnt + 2'd1;
        if (out_cnt == 2'd3) begin
          blk_cnt <= blk_cnt + 16'd1;
        end
      end
    end
  end

  // Source rows are written as they arrive; the whole coefficient block is sampled in the single CAPT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_buf  <= '0;
      coef_buf <= '0;
    end else if (!flush_i) begin
      if (in_acc) begin
        src_buf[in_cnt] <= in_row_i;
      end
      if (state == CAPT) begin
        coef_buf <= dct_coef_i;
      end
    end
  end

  assign dct_src_o = src_buf;
  assign out_row_o = coef_buf[out_cnt];
  assign busy_o    = (state != LOAD) || (in_cnt != 2'd0);
  assign blk_cnt_o = blk_cnt;

endmodule

// File: doc/tq_dct_ctrl.md
TQ_DCT_CTRL -- requirements
Module: tq_dct_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset: clk input 1 (rising edge), rst_n input 1 (active low, asynchronous assert; only reset in block).
REQ-002 The block SHALL provide flush_i input 1: synchronous abort of the block in progress.
REQ-003 The block SHALL provide the residual-row input handshake in_valid_i input 1, in_ready_o output 1, in_row_i input 36 (4 lanes x 9b signed; lane c at [9c+8:9c], c=0 is the leftmost pixel).
REQ-004 The block SHALL drive dct_src_o output 144 to the 4x4 DCT datapath (16 x 9b; sample (r,c) at index k=4r+c, bits [9k+8:9k]).
REQ-005 The block SHALL accept dct_coef_i input 240 from the datapath (16 x 15b signed; coefficient k=4r+c at [15k+14:15k]).
REQ-006 The block SHALL provide the coefficient-row output handshake out_valid_o output 1, out_ready_i input 1, out_row_o output 60 (4 lanes x 15b; lane c = coefficient (r,c)), out_last_o output 1 (high with row 3).
REQ-007 The block SHALL provide busy_o output 1 (state != LOAD or row count != 0) and blk_cnt_o output 16 (count of completed blocks, wraps).

Function
REQ-008 The FSM SHALL have exactly three states: LOAD, CAPT, OUT.
REQ-009 In LOAD, in_ready_o SHALL be 1; each cycle with in_valid_i & in_ready_o SHALL write in_row_i into source-buffer row in_cnt (2b) and increment in_cnt.
REQ-010 Acceptance of row 3 SHALL set in_cnt to 0 and move the FSM to CAPT on the next edge.
REQ-011 In CAPT (exactly 1 cycle), in_ready_o SHALL be 0 and all 240 bits of dct_coef_i SHALL be registered into the coefficient buffer; the next state SHALL be OUT.
REQ-012 dct_src_o SHALL be driven directly from the source buffer at all times, so it is stable throughout CAPT.
REQ-013 In OUT, out_valid_o SHALL be 1, out_row_o SHALL be coefficient-buffer row out_cnt (2b), and out_last_o SHALL equal (out_cnt==3).
REQ-014 While in OUT, each out_valid_o & out_ready_i cycle SHALL increment out_cnt.
REQ-015 Acceptance of row 3 SHALL return the FSM to LOAD, clear out_cnt, and increment blk_cnt_o mod 2^16.
REQ-016 While out_valid_o=1 and out_ready_i=0, out_row_o and out_last_o SHALL hold stable.
REQ-017 out_valid_o SHALL NOT depend combinationally on out_ready_i.
REQ-018 Latency SHALL be: row-3 input accepted in cycle T -> CAPT in T+1 -> out_valid_o=1 with row 0 in T+2, so with out_ready_i held at 1 the last row is accepted in T+5.
REQ-019 Blocks SHALL NOT overlap: in_ready_o SHALL be 0 in CAPT and OUT, so the next block's row 0 is accepted no earlier than the cycle after row 3 is output.
REQ-020 The controller SHALL pass data through unmodified: no arithmetic, saturation or reordering other than the index mapping in REQ-004/005/013.
REQ-021 flush_i=1 SHALL take precedence over every handshake in the same cycle: on the next edge the FSM SHALL be in LOAD, in_cnt and out_cnt SHALL be 0, and out_valid_o SHALL be 0.
REQ-022 A flush SHALL NOT increment blk_cnt_o, and rows accepted or presented in the flush cycle SHALL be discarded.
REQ-023 Buffer contents SHALL be left unchanged by flush; they are don't-care until rewritten.

Reset
REQ-024 On rst_n=0 the block SHALL, asynchronously, enter LOAD with in_cnt=0, out_cnt=0 and blk_cnt_o=0, and drive out_valid_o=0, out_last_o=0, in_ready_o=1 and busy_o=0.
REQ-025 On rst_n=0, out_row_o, dct_src_o and both buffers SHALL reset to 0.
REQ-026 Reset asserted mid-block SHALL discard all partial state, and reset release SHALL take effect at the first rising clk edge with rst_n=1.

Verification (bench instantiates tq_dct_ctrl plus the 4x4 DCT datapath)
REQ-027 Bench SHALL cover: all 16 samples = +1, out_ready_i=1 -> row 0 = {16,0,0,0} (lane 0..3), rows 1-3 all 0, out_last_o on row 3 only, out_valid_o rises 2 cycles after row-3 input, blk_cnt_o=1.
REQ-028 Bench SHALL cover: same block, out_ready_i=0 for 3 cycles at row 1 -> out_row_o constant for those cycles, no row skipped or duplicated, in_ready_o=0 throughout OUT.
REQ-029 Bench SHALL cover: two blocks back-to-back with in_valid_i always 1 (second block all samples = -1) -> second block row 0 = {-16,0,0,0}, rows 1-3 all 0, in_ready_o low from CAPT through the last output row, blk_cnt_o=2.
REQ-030 Bench SHALL cover: flush_i pulsed after 2 input rows -> next accepted row is stored as row 0, and a full block afterwards produces correct output with blk_cnt_o unchanged by the flush.
REQ-031 Bench SHALL cover: rst_n driven low asynchronously (between edges) during OUT row 2 -> out_valid_o=0, blk_cnt_o=0 and in_ready_o=1 immediately, and the next block is processed normally.
REQ-032 Bench SHALL cover: blk_cnt_o preloaded by running 65535 blocks, then 1 more -> blk_cnt_o wraps to 0.
